rr_arb_mux: RTL and testbench
=============================

// Module: rr_arb_mux
// PURPOSE
// - N-to-1 counterpart to the parametric demux: merges p_ninputs val/rdy message streams onto one output stream.
// - Sits at the merge side of a router port.
// - Fair round-robin arbitration feeds a one-entry registered output stage.
// - Sustains one message per cycle with 1-cycle latency.
// PARAMETERS
// - p_nbits     1  width of each message
// - p_ninputs   2  number of input streams (>=1, any integer, need not be a power of 2)
// - c_sbits     derived localparam = (p_ninputs>1) ? $clog2(p_ninputs) : 1
// PORTS
// - clk        in   1                  clock; all state updates on rising edge
// - reset      in   1                  asynchronous, active-low (asserted when 0)
// - recv_msg   in   p_ninputs*p_nbits  flattened inputs; input i at [(p_ninputs-1-i)*p_nbits +: p_nbits] (input 0 in MSBs)
// - recv_val   in   p_ninputs          bit i: input i holds a valid message
// - recv_rdy   out  p_ninputs          bit i: input i is accepted this cycle
// - send_msg   out  p_nbits            buffered message
// - send_val   out  1                  output register full
// - send_rdy   in   1                  downstream accepts send_msg
// - send_src   out  c_sbits            source index of send_msg (RR_ARB_MUX_SRC_TAG_EN only)
// BEHAVIOUR
// - State:
//   - out_full (1b)
//   - out_msg (p_nbits)
//   - out_src (c_sbits)
//   - rr_ptr (c_sbits): index of the highest-priority input
// - Reset (async, while reset==0): out_full=0, out_msg=0, out_src=0, rr_ptr=0.
//   - Outputs during reset: send_val=0, send_msg=0, recv_rdy=0.
//   - A buffered message is discarded on reset mid-operation.
// - can_accept = !out_full || send_rdy
// - Grant (combinational):
//   - If can_accept, grant the first input i with recv_val[i]=1, scanning rr_ptr, rr_ptr+1, ... with wrap p_ninputs-1 -> 0.
//   - recv_rdy is one-hot at the granted input, or all zero.
//   - recv_rdy depends combinationally on recv_val and send_rdy; senders must not derive val from rdy.
// - Transfer on input i (recv_val[i]&&recv_rdy[i]):
//   - out_msg<=msg i, out_src<=i, out_full<=1.
//   - rr_ptr<=(i==p_ninputs-1)?0:i+1.
// - Else if out_full&&send_rdy: out_full<=0. rr_ptr holds.
// - Simultaneous drain and accept in one cycle is legal: the output stays full with the new message.
//   - Back-to-back streaming reaches 1 msg/cycle.
// - No valid input: rr_ptr is unchanged and no grant is issued.
// - send_val=out_full and send_msg=out_msg.
//   - send_msg and send_val are held stable while send_val&&!send_rdy.
// - Latency: accepted in cycle t -> send_val=1 in cycle t+1.
// - p_ninputs=1: rr_ptr is constant 0; the block degenerates to a one-entry pipeline register.
// CONFIGURATION
// - RR_ARB_MUX_SRC_TAG_EN defined: port send_src exists and is driven from out_src (reset value 0).
// - Undefined: port send_src and register out_src are absent; all other behaviour is identical.
// TESTING
// - Reset: reset=0 with recv_val=all 1s -> recv_rdy=0, send_val=0. Release -> first grant goes to input 0.
// - Fairness: N=4, p_nbits=8, all val=1 constantly, send_rdy=1
//   -> sources accepted in order 0,1,2,3,0; one msg/cycle.
//   - With SRC_TAG_EN: send_src follows 0,1,2,3.
// - Backpressure: send_rdy=0, in0 sends 0xA5 -> send_val=1, send_msg=0xA5.
//   - While full and blocked: recv_rdy=0.
//   - 3 stall cycles, 0xA5 held; send_rdy=1 -> next msg loads the same cycle.
// - Wrap and skip: N=3, rr_ptr=2, only in0 valid -> in0 granted, rr_ptr->1.
//   - Then only in2 valid -> in2 granted, rr_ptr->0.
// - Mid-op reset: output full with 0x3C, reset pulse -> send_val=0 immediately (async); no stale message after release.
// - Degenerate: N=1 -> stream of 0x01..0x10 passes in order with 1-cycle latency under random send_rdy.

Source files
------------

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: merges p_ninputs val/rdy streams through a round-robin grant into a one-entry output register.
// Define RR_ARB_MUX_SRC_TAG_EN to add the send_src port, which carries the source index of send_msg.
module rr_arb_mux #(
  parameter int  p_nbits   = 1,
  parameter int  p_ninputs = 2,
  localparam int c_sbits   = (p_ninputs > 1) ? $clog2(p_ninputs) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [p_ninputs*p_nbits-1:0] recv_msg,
  input  logic [p_ninputs-1:0]         recv_val,
  output logic [p_ninputs-1:0]         recv_rdy,
  output logic [p_nbits-1:0]           send_msg,
  output logic                         send_val,
  input  logic                         send_rdy
`ifdef RR_ARB_MUX_SRC_TAG_EN
  ,
  output logic [c_sbits-1:0]           send_src
`endif
);

  localparam logic [c_sbits-1:0] c_last = c_sbits'(p_ninputs - 1);

  logic                 out_full;
  logic [p_nbits-1:0]   out_msg;
  logic [c_sbits-1:0]   rr_ptr;

  logic [p_nbits-1:0]   in_msg [p_ninputs];
  logic                 can_accept;
  logic                 grant_found;
  logic [c_sbits-1:0]   grant_idx;
  logic [p_nbits-1:0]   grant_msg;

  // Input 0 occupies the most significant slice of recv_msg.
  for (genvar i = 0; i < p_ninputs; i++) begin : g_unpack
    assign in_msg[i] = recv_msg[(p_ninputs-1-i)*p_nbits +: p_nbits];
  end

  // A draining output register can take a new message in the same cycle.
  assign can_accept = !out_full || send_rdy;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_msg   = '0;
    recv_rdy    = '0;
    if (reset && can_accept) begin
      // First pass covers rr_ptr..N-1, second pass the wrapped range 0..rr_ptr-1.
      for (int i = 0; i < p_ninputs; i++) begin
        if (!grant_found && recv_val[i] && (i >= int'(rr_ptr))) begin
          grant_found = 1'b1;
          grant_idx   = c_sbits'(i);
          grant_msg   = in_msg[i];
          recv_rdy[i] = 1'b1;
        end
      end
      for (int i = 0; i < p_ninputs; i++) begin
        if (!grant_found && recv_val[i] && (i < int'(rr_ptr))) begin
          grant_found = 1'b1;
          grant_idx   = c_sbits'(i);
          grant_msg   = in_msg[i];
          recv_rdy[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_full <= 1'b0;
      out_msg  <= '0;
      rr_ptr   <= '0;
    end else if (grant_found) begin
      out_full <= 1'b1;
      out_msg  <= grant_msg;
      rr_ptr   <= (grant_idx == c_last) ? '0 : grant_idx + c_sbits'(1);
    end else if (out_full && send_rdy) begin
      out_full <= 1'b0;
    end
  end

`ifdef RR_ARB_MUX_SRC_TAG_EN
  logic [c_sbits-1:0] out_src;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_src <= '0;
    end else if (grant_found) begin
      out_src <= grant_idx;
    end
  end

  assign send_src = out_src;
`endif

  assign send_val = out_full;
  assign send_msg = out_msg;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: three instances (N=4, N=3, N=1) checked against a queue-free behavioural model.
// Directed reset/fairness/backpressure/wrap/mid-op-reset steps, then a randomized phase with an N=1 ordered stream.
module tb_rr_arb_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] in_msg [3][4];
  logic [3:0] in_val [3];
  logic       srdy   [3];

  int n_cmp = 0;
  int n_err = 0;

  bit         m_full [3];
  logic [7:0] m_msg  [3];
  int         m_src  [3];
  int         m_ptr  [3];
  int         m_took [3];
  logic [3:0] last_rdy [3];
  bit         stream_c;
  int         c_in_next;
  int         c_out_next;

  logic [31:0] msg_a;  logic [3:0] val_a, rdy_a; logic [7:0] smsg_a; logic sval_a, srdy_a;
  logic [23:0] msg_b;  logic [2:0] val_b, rdy_b; logic [7:0] smsg_b; logic sval_b, srdy_b;
  logic [7:0]  msg_c;  logic [0:0] val_c, rdy_c; logic [7:0] smsg_c; logic sval_c, srdy_c;
  logic [1:0]  src_a, src_b;
  logic [0:0]  src_c;

  assign msg_a  = {in_msg[0][0], in_msg[0][1], in_msg[0][2], in_msg[0][3]};
  assign msg_b  = {in_msg[1][0], in_msg[1][1], in_msg[1][2]};
  assign msg_c  = in_msg[2][0];
  assign val_a  = in_val[0];
  assign val_b  = in_val[1][2:0];
  assign val_c  = in_val[2][0:0];
  assign srdy_a = srdy[0];
  assign srdy_b = srdy[1];
  assign srdy_c = srdy[2];

  rr_arb_mux #(.p_nbits(8), .p_ninputs(4)) u_a (
    .clk(clk), .reset(reset), .recv_msg(msg_a), .recv_val(val_a), .recv_rdy(rdy_a),
    .send_msg(smsg_a), .send_val(sval_a), .send_rdy(srdy_a)
`ifdef RR_ARB_MUX_SRC_TAG_EN
    , .send_src(src_a)
`endif
  );

  rr_arb_mux #(.p_nbits(8), .p_ninputs(3)) u_b (
    .clk(clk), .reset(reset), .recv_msg(msg_b), .recv_val(val_b), .recv_rdy(rdy_b),
    .send_msg(smsg_b), .send_val(sval_b), .send_rdy(srdy_b)
`ifdef RR_ARB_MUX_SRC_TAG_EN
    , .send_src(src_b)
`endif
  );

  rr_arb_mux #(.p_nbits(8), .p_ninputs(1)) u_c (
    .clk(clk), .reset(reset), .recv_msg(msg_c), .recv_val(val_c), .recv_rdy(rdy_c),
    .send_msg(smsg_c), .send_val(sval_c), .send_rdy(srdy_c)
`ifdef RR_ARB_MUX_SRC_TAG_EN
    , .send_src(src_c)
`endif
  );

`ifndef RR_ARB_MUX_SRC_TAG_EN
  assign src_a = '0;
  assign src_b = '0;
  assign src_c = '0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int nin(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 3 : 1);
  endfunction

  // First valid input at or after ptr, wrapping modulo n; -1 when none.
  function automatic int pick(input int n, input int ptr, input logic [3:0] v);
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = (ptr + k) % n;
      if (v[idx] === 1'b1) return idx;
    end
    return -1;
  endfunction

  function automatic int model_grant(input int d);
    if (reset !== 1'b1) return -1;
    if (m_full[d] && !srdy[d]) return -1;
    return pick(nin(d), m_ptr[d], in_val[d]);
  endfunction

  function automatic logic [3:0] obs_rdy(input int d);
    case (d)
      0:       return rdy_a;
      1:       return {1'b0, rdy_b};
      default: return {3'b000, rdy_c};
    endcase
  endfunction

  function automatic logic [7:0] obs_msg(input int d);
    case (d)
      0:       return smsg_a;
      1:       return smsg_b;
      default: return smsg_c;
    endcase
  endfunction

  function automatic logic obs_val(input int d);
    case (d)
      0:       return sval_a;
      1:       return sval_b;
      default: return sval_c;
    endcase
  endfunction

  function automatic logic [1:0] obs_src(input int d);
    case (d)
      0:       return src_a;
      1:       return src_b;
      default: return {1'b0, src_c};
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_full[d] = 1'b0;
      m_msg[d]  = 8'h00;
      m_src[d]  = 0;
      m_ptr[d]  = 0;
      m_took[d] = -1;
    end
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      in_val[d] = 4'b0000;
      srdy[d]   = 1'b1;
    end
  endtask

  // Check at the falling edge, advance the model at the rising edge, return just after it.
  task automatic tick();
    int g [3];
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      logic [3:0] e;
      e = 4'b0000;
      g[d] = model_grant(d);
      if (g[d] >= 0) e[g[d]] = 1'b1;
      last_rdy[d] = obs_rdy(d);
      chk($sformatf("recv_rdy[%0d]", d), last_rdy[d], e);
      chk($sformatf("send_val[%0d]", d), obs_val(d), m_full[d]);
      chk($sformatf("send_msg[%0d]", d), obs_msg(d), m_msg[d]);
`ifdef RR_ARB_MUX_SRC_TAG_EN
      chk($sformatf("send_src[%0d]", d), obs_src(d), m_src[d]);
`endif
    end
    if (stream_c && m_full[2] && srdy[2]) begin
      chk("n1_order", smsg_c, c_out_next);
      c_out_next++;
    end
    @(posedge clk);
    if (reset !== 1'b1) begin
      model_reset();
    end else begin
      for (int d = 0; d < 3; d++) begin
        m_took[d] = g[d];
        if (g[d] >= 0) begin
          m_msg[d]  = in_msg[d][g[d]];
          m_src[d]  = g[d];
          m_full[d] = 1'b1;
          m_ptr[d]  = (g[d] == nin(d) - 1) ? 0 : g[d] + 1;
        end else if (m_full[d] && srdy[d]) begin
          m_full[d] = 1'b0;
        end
      end
    end
    #1;
  endtask

  initial begin
    stream_c   = 1'b0;
    c_in_next  = 1;
    c_out_next = 1;
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 4; k++) in_msg[d][k] = 8'($urandom);
      in_val[d]   = 4'b1111;
      srdy[d]     = 1'($urandom);
      last_rdy[d] = 4'b0000;
    end
    model_reset();

    // Reset with all inputs valid: nothing granted, nothing sent.
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("rst_rdy_a", rdy_a, 4'b0000);
    chk("rst_rdy_b", {1'b0, rdy_b}, 4'b0000);
    chk("rst_val_a", sval_a, 1'b0);
    chk("rst_msg_a", smsg_a, 8'h00);
    tick();
    tick();
    reset = 1'b1;

    // Fairness: everything valid, downstream always ready.
    for (int d = 0; d < 3; d++) begin
      in_val[d] = 4'b1111;
      srdy[d]   = 1'b1;
    end
    for (int k = 0; k < 5; k++) begin
      for (int d = 0; d < 3; d++)
        for (int j = 0; j < 4; j++) in_msg[d][j] = 8'($urandom);
      tick();
      chk("fair_order", last_rdy[0], 4'b0001 << (k % 4));
      chk("fair_val", sval_a, 1'b1);
      if (k == 0) chk("first_grant_b", last_rdy[1], 4'b0001);
`ifdef RR_ARB_MUX_SRC_TAG_EN
      chk("fair_src", src_a, k % 4);
`endif
    end

    // Backpressure on the N=4 instance.
    idle_all();
    tick();
    srdy[0]      = 1'b0;
    in_val[0]    = 4'b0001;
    in_msg[0][0] = 8'hA5;
    tick();
    chk("bp_val", sval_a, 1'b1);
    chk("bp_msg", smsg_a, 8'hA5);
    in_val[0] = 4'b1111;
    for (int j = 0; j < 4; j++) in_msg[0][j] = 8'h10 + 8'(j);
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("bp_blocked_rdy", last_rdy[0], 4'b0000);
      chk("bp_hold_msg", smsg_a, 8'hA5);
      chk("bp_hold_val", sval_a, 1'b1);
    end
    srdy[0] = 1'b1;
    tick();
    chk("bp_reload_rdy", last_rdy[0], 4'b0010);
    chk("bp_reload_msg", smsg_a, 8'h11);
    chk("bp_reload_val", sval_a, 1'b1);

    // Wrap and skip on the N=3 instance.
    idle_all();
    for (int j = 0; j < 3; j++) in_msg[1][j] = 8'hB0 + 8'(j);
    in_val[1] = 4'b0010;
    tick();
    in_val[1] = 4'b0001;
    tick();
    chk("wrap_rdy", last_rdy[1], 4'b0001);
    chk("wrap_msg", smsg_b, 8'hB0);
    in_val[1] = 4'b0100;
    tick();
    chk("skip_rdy", last_rdy[1], 4'b0100);
    chk("skip_msg", smsg_b, 8'hB2);
    in_val[1] = 4'b0111;
    tick();
    chk("ptr_zero_rdy", last_rdy[1], 4'b0001);

    // Mid-operation reset while the N=4 output holds 0x3C.
    idle_all();
    tick();
    srdy[0]      = 1'b0;
    in_val[0]    = 4'b0001;
    in_msg[0][0] = 8'h3C;
    tick();
    chk("mr_full_msg", smsg_a, 8'h3C);
    in_val[0] = 4'b1111;
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("mr_val_async", sval_a, 1'b0);
    chk("mr_msg_async", smsg_a, 8'h00);
    chk("mr_rdy_async", rdy_a, 4'b0000);
    tick();
    reset     = 1'b1;
    in_val[0] = 4'b0000;
    tick();
    chk("mr_no_stale", sval_a, 1'b0);

    // Randomized traffic; the N=1 instance carries the ordered stream 0x01..0x10.
    idle_all();
    tick();
    stream_c = 1'b1;
    for (int it = 0; it < 300; it++) begin
      for (int d = 0; d < 2; d++) begin
        in_val[d] = 4'($urandom_range(0, 15));
        for (int j = 0; j < 4; j++) in_msg[d][j] = 8'($urandom);
      end
      for (int d = 0; d < 3; d++) srdy[d] = 1'($urandom);
      in_msg[2][0] = 8'(c_in_next);
      in_val[2]    = (c_in_next <= 16) ? 4'b0001 : 4'b0000;
      tick();
      if (m_took[2] >= 0) c_in_next++;
    end
    chk("n1_count", c_out_next, 17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
